uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised, runtime-configurable UART transmitter. It is the next generation of the fixed 8N1 transmitter. It adds:
- a parametrised-depth transmit FIFO with fill-level reporting and overflow flagging;
- a programmable baud divisor;
- 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits.

It sits between the host-side byte-write interface and the serial pin.

## Interface
Parameters:
- FIFO_DEPTH, 16, transmit FIFO entries; power of two, 2..256
- DIV_WIDTH, 16, width of baud divisor
- LVL_WIDTH, $clog2(FIFO_DEPTH)+1, width of level/threshold signals (derived)

Ports:
- clock_i  in  1  single clock; all logic rises on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- data_i  in  8  byte to enqueue; bits above the configured length ignored
- data_write_i  in  1  enqueue strobe, one entry per cycle high
- data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_mode_i  in  2  00/11=none, 01=even, 10=odd
- stop_bits_i  in  1  0=one stop bit, 1=two stop bits
- baud_div_i  in  DIV_WIDTH  clocks per bit minus one (0 = 1 clock/bit)
- full_tresh_i  in  LVL_WIDTH  almost-full threshold
- data_buffer_full_o  out  1  high while fifo_level_o >= full_tresh_i (combinational from level)
- fifo_level_o  out  LVL_WIDTH  current number of stored entries
- overflow_o  out  1  one-cycle pulse when a write is dropped
- tx_busy_o  out  1  high while a frame is on the line (state != IDLE)
- uart_tx_o  out  1  serial output, registered, idle high

## Operation
- Reset values: FIFO empty, fifo_level_o=0, overflow_o=0, tx_busy_o=0, uart_tx_o=1, FSM=IDLE, baud counter=0.
- Reset is asynchronous. Asserting it mid-frame forces uart_tx_o=1 immediately and discards the FIFO contents.

FIFO:
- A write is accepted iff level < FIFO_DEPTH before that cycle's pop.
- A write at full is dropped and pulses overflow_o for one cycle. The level is unchanged.
- Simultaneous accepted write and pop: level unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when the FIFO is non-empty, pop the head entry into the shift register. At the same time, latch data_bits_i, parity_mode_i, stop_bits_i and baud_div_i. Go to START.
  - Config inputs changing mid-frame have no effect until the next frame.
- START: drive 0 for one bit period, then go to DATA.
- DATA: drive LSB first. After N bits (N = latched length), go to PARITY if parity is enabled, else STOP.
- PARITY:
  - even: bit = XOR of the N data bits;
  - odd: inverted XOR;
  - one bit period.
- STOP: drive 1 for one bit period, or two if stop_bits=1.
  - At the end of the last stop bit, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.

Bit timing:
- Each bit period lasts baud_div+1 clocks.
- The counter reloads at every bit boundary and counts down to 0.
- The bit boundary is the cycle in which the counter is 0.

## Timing
- Write latency: data_write_i high at edge k → fifo_level_o updated after edge k.
- Frame start: the FSM pops at edge k+1, and uart_tx_o falls after edge k+1. That is 2 cycles from strobe to start bit when idle.
- The pop decrements the level after the same edge that loads the shift register.
- Frame length in clocks = (baud_div+1) × (1 + N + P + S), where P∈{0,1} and S∈{1,2}.
- tx_busy_o is high from the cycle uart_tx_o first goes low until the cycle after the final stop bit ends with the FIFO empty.
- overflow_o is asserted in the cycle following the dropped write edge.
- data_buffer_full_o tracks the level with zero added latency.

## Test plan
- 8N1 frame: baud_div=3, write 0x55 → uart_tx_o low 4 clocks, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then high 4 clocks; frame = 40 clocks; tx_busy_o high exactly 40 clocks.
- 7E2 frame: data_bits=10, parity=01, stop=1, baud_div=0, write 0x41 → 11-clock frame: 0, 1,0,0,0,0,0,1, parity 0, 1, 1.
- 5O1 frame: write 0xFF with 5 bits, parity odd → data 1,1,1,1,1, then parity 0; bits 7:5 ignored.
- Back-to-back and overflow: FIFO_DEPTH=4, baud_div=1, 6 consecutive writes →
  - level peaks at 4;
  - exactly one overflow_o pulse, on the 6th write (the first write pops at cycle 2);
  - 5 frames sent with no idle gap;
  - level returns to 0.
- Threshold: full_tresh_i=3 → data_buffer_full_o rises with the level reaching 3 and falls when the level drops to 2.
- Reset mid-frame: assert reset_n_i during DATA → uart_tx_o=1 and level=0 immediately. After release, no frame is sent until a new write.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: FIFO-buffered bytes are framed with
// 5-8 data bits, optional even/odd parity and 1 or 2 stop bits at a programmable baud.
module uart_tx_cfg #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [7:0]           data_i,
    input  logic                 data_write_i,
    input  logic [1:0]           data_bits_i,
    input  logic [1:0]           parity_mode_i,
    input  logic                 stop_bits_i,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    input  logic [LVL_WIDTH-1:0] full_tresh_i,
    output logic                 data_buffer_full_o,
    output logic [LVL_WIDTH-1:0] fifo_level_o,
    output logic                 overflow_o,
    output logic                 tx_busy_o,
    output logic                 uart_tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [LVL_WIDTH-1:0] DEPTH_LVL = LVL_WIDTH'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_WIDTH-1:0] level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 wr_accept, pop, fifo_empty;
    logic [7:0]           head, mask;

    state_t               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           bit_idx_q, bit_idx_d, nbits_q, nbits_d;
    logic                 par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d, stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 boundary;

    // Acceptance looks at the level before this cycle's pop, so a write at full is dropped.
    assign wr_accept  = data_write_i && (level_q < DEPTH_LVL);
    assign fifo_empty = (level_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign boundary   = (cnt_q == '0);

    always_comb begin
        case (data_bits_i)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (wr_accept) mem_q[wr_ptr_q] <= data_i;
    end

    always_comb begin
        wr_ptr_d   = wr_accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = data_write_i && !wr_accept;
        level_d    = level_q;
        if (wr_accept && !pop)      level_d = level_q + LVL_WIDTH'(1);
        else if (!wr_accept && pop) level_d = level_q - LVL_WIDTH'(1);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = boundary ? cnt_q : cnt_q - DIV_WIDTH'(1);
        div_d      = div_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        nbits_d    = nbits_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        tx_d       = tx_q;
        pop        = 1'b0;

        // A new frame starts from IDLE or straight out of the last stop bit.
        if (!fifo_empty && ((state_q == IDLE) ||
            (state_q == STOP && boundary && !(stop2_q && !stop_idx_q)))) begin
            pop       = 1'b1;
            shreg_d   = head & mask;
            nbits_d   = {1'b1, data_bits_i};
            par_en_d  = (parity_mode_i == 2'b01) || (parity_mode_i == 2'b10);
            par_bit_d = (^(head & mask)) ^ (parity_mode_i == 2'b10);
            stop2_d   = stop_bits_i;
            div_d     = baud_div_i;
            cnt_d     = baud_div_i;
            tx_d      = 1'b0;
            state_d   = START;
        end else if (boundary) begin
            cnt_d = div_q;
            case (state_q)
                START: begin
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_idx_q == nbits_q) begin
                        tx_d       = par_en_q ? par_bit_q : 1'b1;
                        stop_idx_d = 1'b0;
                        state_d    = par_en_q ? PARITY : STOP;
                    end else begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = STOP;
                end
                STOP: begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            nbits_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            nbits_q    <= nbits_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end

    assign fifo_level_o       = level_q;
    assign data_buffer_full_o = (level_q >= full_tresh_i);
    assign overflow_o         = overflow_q;
    assign tx_busy_o          = (state_q != IDLE);
    assign uart_tx_o          = tx_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: fixed frames, back-to-back with overflow,
// almost-full threshold and asynchronous reset mid-frame.
module tb_uart_tx_cfg;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    data_i = '0;
    logic          data_write_i = 1'b0;
    logic [1:0]    data_bits_i = 2'b11;
    logic [1:0]    parity_mode_i = 2'b00;
    logic          stop_bits_i = 1'b0;
    logic [DW-1:0] baud_div_i = 16'd3;
    logic [LW-1:0] full_tresh_i = 3'd3;
    logic          data_buffer_full_o;
    logic [LW-1:0] fifo_level_o;
    logic          overflow_o;
    logic          tx_busy_o;
    logic          uart_tx_o;

    int checks = 0;
    int failures = 0;

    logic          cap_en = 1'b0;
    int            cap_n = 0;
    logic          cap_tx   [256];
    logic          cap_busy [256];
    logic          cap_ovf  [256];
    logic          cap_full [256];
    logic [LW-1:0] cap_lvl  [256];

    always #5 clk = ~clk;

    uart_tx_cfg #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW), .LVL_WIDTH(LW)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .data_i(data_i), .data_write_i(data_write_i),
        .data_bits_i(data_bits_i), .parity_mode_i(parity_mode_i), .stop_bits_i(stop_bits_i),
        .baud_div_i(baud_div_i), .full_tresh_i(full_tresh_i),
        .data_buffer_full_o(data_buffer_full_o), .fifo_level_o(fifo_level_o),
        .overflow_o(overflow_o), .tx_busy_o(tx_busy_o), .uart_tx_o(uart_tx_o)
    );

    // Sample index k holds the outputs just after the k-th captured rising edge.
    always begin
        @(posedge clk);
        #2;
        if (cap_en && cap_n < 256) begin
            cap_tx[cap_n]   = uart_tx_o;
            cap_busy[cap_n] = tx_busy_o;
            cap_ovf[cap_n]  = overflow_o;
            cap_full[cap_n] = data_buffer_full_o;
            cap_lvl[cap_n]  = fifo_level_o;
            cap_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        data_i = d;
        data_write_i = 1'b1;
        @(negedge clk);
        data_write_i = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (uart_tx_o !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start_bit"}, {31'b0, uart_tx_o}, 32'd0);
        chk({tag, "_start_latency"}, n, 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [11:0] bits, input int len, input int div);
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c <= div; c++) begin
                chk($sformatf("%s_bit%0d_clk%0d", tag, b, c), {31'b0, uart_tx_o}, {31'b0, bits[b]});
                chk($sformatf("%s_busy%0d_clk%0d", tag, b, c), {31'b0, tx_busy_o}, 32'd1);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        logic [7:0] bytes [6];
        logic [9:0] fr;
        logic       saw_activity;
        int         s;
        bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'h3C;
        bytes[3] = 8'hC3; bytes[4] = 8'hFF; bytes[5] = 8'h77;

        repeat (2) @(negedge clk);
        chk("rst_tx", {31'b0, uart_tx_o}, 32'd1);
        chk("rst_busy", {31'b0, tx_busy_o}, 32'd0);
        chk("rst_level", {29'b0, fifo_level_o}, 32'd0);
        chk("rst_ovf", {31'b0, overflow_o}, 32'd0);
        chk("rst_full", {31'b0, data_buffer_full_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1, 0x55, 4 clocks/bit; config is scrambled once the frame has started
        data_bits_i = 2'b11; parity_mode_i = 2'b00; stop_bits_i = 1'b0; baud_div_i = 16'd3;
        push(8'h55);
        chk("8n1_level_after_write", {29'b0, fifo_level_o}, 32'd1);
        chk("8n1_idle_before_pop", {31'b0, tx_busy_o}, 32'd0);
        wait_start("8n1");
        chk("8n1_level_after_pop", {29'b0, fifo_level_o}, 32'd0);
        data_bits_i = 2'b00; parity_mode_i = 2'b01; stop_bits_i = 1'b1; baud_div_i = 16'd0;
        check_frame("8n1", 12'h2AA, 10, 3);
        chk("8n1_busy_end", {31'b0, tx_busy_o}, 32'd0);
        chk("8n1_tx_end", {31'b0, uart_tx_o}, 32'd1);

        // 7E2, 0x41, 1 clock/bit
        data_bits_i = 2'b10; parity_mode_i = 2'b01; stop_bits_i = 1'b1; baud_div_i = 16'd0;
        push(8'h41);
        wait_start("7e2");
        check_frame("7e2", 12'h682, 11, 0);
        chk("7e2_busy_end", {31'b0, tx_busy_o}, 32'd0);
        chk("7e2_tx_end", {31'b0, uart_tx_o}, 32'd1);

        // 5O1, 0xFF: upper bits ignored, odd parity over five ones is 0
        data_bits_i = 2'b00; parity_mode_i = 2'b10; stop_bits_i = 1'b0; baud_div_i = 16'd0;
        push(8'hFF);
        wait_start("5o1");
        check_frame("5o1", 12'h0BE, 8, 0);
        chk("5o1_busy_end", {31'b0, tx_busy_o}, 32'd0);
        chk("5o1_tx_end", {31'b0, uart_tx_o}, 32'd1);

        // Back-to-back: six writes into a 4-deep FIFO at 2 clocks/bit
        data_bits_i = 2'b11; parity_mode_i = 2'b00; stop_bits_i = 1'b0; baud_div_i = 16'd1;
        full_tresh_i = 3'd3;
        cap_n = 0;
        cap_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data_i = bytes[k];
            data_write_i = 1'b1;
            @(negedge clk);
        end
        data_write_i = 1'b0;
        repeat (110) @(negedge clk);
        cap_en = 1'b0;
        chk("b2b_capture_len", {31'b0, cap_n >= 103}, 32'd1);
        begin
            logic [2:0] lvl_exp [6];
            lvl_exp[0] = 3'd1; lvl_exp[1] = 3'd1; lvl_exp[2] = 3'd2;
            lvl_exp[3] = 3'd3; lvl_exp[4] = 3'd4; lvl_exp[5] = 3'd4;
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("b2b_level_w%0d", k), {29'b0, cap_lvl[k]}, {29'b0, lvl_exp[k]});
                chk($sformatf("b2b_full_w%0d", k), {31'b0, cap_full[k]}, {31'b0, lvl_exp[k] >= 3'd3});
            end
        end
        for (int k = 0; k < 9; k++)
            chk($sformatf("b2b_ovf_%0d", k), {31'b0, cap_ovf[k]}, {31'b0, k == 5});
        chk("b2b_idle_before", {31'b0, cap_busy[0]}, 32'd0);
        for (int f = 0; f < 5; f++) begin
            fr = {1'b1, bytes[f], 1'b0};
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < 2; c++) begin
                    s = 1 + 20 * f + 2 * b + c;
                    chk($sformatf("b2b_f%0d_bit%0d_clk%0d", f, b, c), {31'b0, cap_tx[s]}, {31'b0, fr[b]});
                    chk($sformatf("b2b_f%0d_busy%0d_clk%0d", f, b, c), {31'b0, cap_busy[s]}, 32'd1);
                end
            end
            if (f > 0) begin
                chk($sformatf("b2b_level_f%0d", f), {29'b0, cap_lvl[1 + 20 * f]}, 32'(4 - f));
                chk($sformatf("b2b_full_f%0d", f), {31'b0, cap_full[1 + 20 * f]}, {31'b0, f == 1});
            end
        end
        chk("b2b_busy_after", {31'b0, cap_busy[101]}, 32'd0);
        chk("b2b_tx_after", {31'b0, cap_tx[101]}, 32'd1);
        chk("b2b_level_after", {29'b0, cap_lvl[101]}, 32'd0);

        // Asynchronous reset while in the data bits with one entry still queued
        baud_div_i = 16'd3;
        push(8'hAA);
        wait_start("rst");
        push(8'h33);
        repeat (8) @(negedge clk);
        chk("rst_mid_level_before", {29'b0, fifo_level_o}, 32'd1);
        chk("rst_mid_busy_before", {31'b0, tx_busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_tx", {31'b0, uart_tx_o}, 32'd1);
        chk("rst_mid_level", {29'b0, fifo_level_o}, 32'd0);
        chk("rst_mid_busy", {31'b0, tx_busy_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_activity = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1 || tx_busy_o !== 1'b0) saw_activity = 1'b1;
        end
        chk("rst_quiet_after_release", {31'b0, saw_activity}, 32'd0);
        push(8'h0F);
        wait_start("post_rst");
        check_frame("post_rst", 12'h21E, 10, 3);
        chk("post_rst_busy_end", {31'b0, tx_busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
